// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the hazard/forwarding controller: forwarding mux selects,
// the load ResultSrc code and the control half of an E-stage shadow entry.
package hazard_forward_unit_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   typedef struct packed {
      logic regwrite;
      logic is_load;
   } stage_ctl_t;

   localparam stage_ctl_t CTL_BUBBLE = '{regwrite: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side view of the hazard unit: D-stage fields and control in,
// forwarding selects, stall/flush strobes and performance counters out.
interface hazard_forward_unit_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   import hazard_forward_unit_pkg::*;

   logic [REG_AW-1:0] rs1_d;
   logic [REG_AW-1:0] rs2_d;
   logic [REG_AW-1:0] rd_d;
   logic              valid_d;
   logic              regwrite_d;
   logic [1:0]        result_src_d;
   logic              pcsrc_e;
   logic              ext_stall;
   logic              clr_cnt;
   fwd_sel_t          fwd_a_e;
   fwd_sel_t          fwd_b_e;
   logic              stall_f;
   logic              stall_d;
   logic              flush_d;
   logic              flush_e;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output rs1_d, rs2_d, rd_d, valid_d, regwrite_d, result_src_d,
      output pcsrc_e, ext_stall, clr_cnt,
      input  fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  rs1_d, rs2_d, rd_d, valid_d, regwrite_d, result_src_d,
      input  pcsrc_e, ext_stall, clr_cnt,
      output fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e,
      output stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Forwarding select for one E-stage ALU operand, chosen from the M and W
// shadow destinations.
module hazard_forward_unit_fwd_select
   import hazard_forward_unit_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] rd_m,
   input  logic              regwrite_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              regwrite_w,
   output fwd_sel_t          sel
);

   // Youngest in-flight writer wins; x0 is never forwarded.
   always_comb begin
      sel = FWD_RF;
      if (src == {REG_AW{1'b0}}) begin
         sel = FWD_RF;
      end else if (regwrite_m && (rd_m == src)) begin
         sel = FWD_MEM;
      end else if (regwrite_w && (rd_w == src)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_RF;
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: keeps a shadow copy of
// E/M/W register usage and derives forwarding, stall, flush and event counters.
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
#(
   parameter int REG_AW         = 5,
   parameter bit RF_WRITE_FIRST = 1'b1,
   parameter int CNT_W          = 16
) (
   input logic                  clk,
   input logic                  reset,
   hazard_forward_unit_if.slave bus
);

   localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);

   logic [REG_AW-1:0] rs1_e_r, rs2_e_r, rd_e_r, rd_m_r, rd_w_r;
   stage_ctl_t        ctl_e_r;
   logic              regwrite_m_r, regwrite_w_r;
   logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
   logic              ld_hit_s, wd_hit_s, hz_s;
   logic              stall_f_s, stall_d_s, flush_d_s, flush_e_s;
   logic              stall_inc_s, flush_inc_s;
   fwd_sel_t          fwd_a_s, fwd_b_s;

   hazard_forward_unit_fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
      .src(rs1_e_r), .rd_m(rd_m_r), .regwrite_m(regwrite_m_r),
      .rd_w(rd_w_r), .regwrite_w(regwrite_w_r), .sel(fwd_a_s)
   );

   hazard_forward_unit_fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
      .src(rs2_e_r), .rd_m(rd_m_r), .regwrite_m(regwrite_m_r),
      .rd_w(rd_w_r), .regwrite_w(regwrite_w_r), .sel(fwd_b_s)
   );

   // Load-use against E, plus W-vs-D read when the regfile is not write-through.
   always_comb begin
      ld_hit_s = ctl_e_r.is_load && (rd_e_r != REG_ZERO) &&
                 ((rd_e_r == bus.rs1_d) || (rd_e_r == bus.rs2_d));
      wd_hit_s = !RF_WRITE_FIRST && regwrite_w_r && (rd_w_r != REG_ZERO) &&
                 ((rd_w_r == bus.rs1_d) || (rd_w_r == bus.rs2_d));
      hz_s     = bus.valid_d && (ld_hit_s || wd_hit_s);
   end

   // Freeze beats branch redirect, which beats (and masks) the data hazard.
   always_comb begin
      stall_f_s = 1'b0;
      stall_d_s = 1'b0;
      flush_d_s = 1'b0;
      flush_e_s = 1'b0;
      if (bus.ext_stall) begin
         stall_f_s = 1'b1;
         stall_d_s = 1'b1;
      end else if (bus.pcsrc_e) begin
         flush_d_s = 1'b1;
         flush_e_s = 1'b1;
      end else if (hz_s) begin
         stall_f_s = 1'b1;
         stall_d_s = 1'b1;
         flush_e_s = 1'b1;
      end else begin
         stall_f_s = 1'b0;
      end
      stall_inc_s = stall_f_s && !bus.ext_stall;
      flush_inc_s = bus.pcsrc_e && !bus.ext_stall;
   end

   // E shadow: capture D, or a bubble when E is being flushed.
   always_ff @(posedge clk) begin
      if (reset) begin
         rs1_e_r <= REG_ZERO;
         rs2_e_r <= REG_ZERO;
         rd_e_r  <= REG_ZERO;
         ctl_e_r <= CTL_BUBBLE;
      end else if (!bus.ext_stall) begin
         if (flush_e_s) begin
            rs1_e_r <= REG_ZERO;
            rs2_e_r <= REG_ZERO;
            rd_e_r  <= REG_ZERO;
            ctl_e_r <= CTL_BUBBLE;
         end else begin
            rs1_e_r <= bus.rs1_d;
            rs2_e_r <= bus.rs2_d;
            rd_e_r  <= bus.rd_d;
            ctl_e_r <= '{regwrite: bus.regwrite_d && bus.valid_d,
                         is_load:  bus.result_src_d == RESULT_SRC_LOAD};
         end
      end
   end

   // M shadow follows E.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_m_r       <= REG_ZERO;
         regwrite_m_r <= 1'b0;
      end else if (!bus.ext_stall) begin
         rd_m_r       <= rd_e_r;
         regwrite_m_r <= ctl_e_r.regwrite;
      end
   end

   // W shadow follows M.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_w_r       <= REG_ZERO;
         regwrite_w_r <= 1'b0;
      end else if (!bus.ext_stall) begin
         rd_w_r       <= rd_m_r;
         regwrite_w_r <= regwrite_m_r;
      end
   end

   // Saturating event counters; frozen along with the pipe.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r <= CNT_ZERO;
         flush_cnt_r <= CNT_ZERO;
      end else if (!bus.ext_stall) begin
         if (bus.clr_cnt) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
         end else begin
            if (stall_inc_s && (stall_cnt_r != CNT_MAX)) stall_cnt_r <= stall_cnt_r + CNT_ONE;
            if (flush_inc_s && (flush_cnt_r != CNT_MAX)) flush_cnt_r <= flush_cnt_r + CNT_ONE;
         end
      end
   end

   assign bus.fwd_a_e   = fwd_a_s;
   assign bus.fwd_b_e   = fwd_b_s;
   assign bus.stall_f   = stall_f_s;
   assign bus.stall_d   = stall_d_s;
   assign bus.flush_d   = flush_d_s;
   assign bus.flush_e   = flush_e_s;
   assign bus.stall_cnt = stall_cnt_r;
   assign bus.flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (write-through/16-bit counters and
// write-late/2-bit counters) driven with the same table, directed and random stimulus.
module tb_hazard_forward_unit;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic v, rw;
      logic [1:0] rsrc;
      logic pc, ext, clr, rst;
   } stim_t;

   typedef struct {
      integer fa, fb, sf, sd, fd, fe, sc, fc;
   } out_t;

   typedef struct {
      stim_t s;
      out_t  o;
   } vec_t;

   typedef struct {
      int rd, rs1, rs2;
      bit wr, ld;
   } inst_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   hazard_forward_unit_if #(.REG_AW(5), .CNT_W(16)) bus0 ();
   hazard_forward_unit_if #(.REG_AW(5), .CNT_W(2))  bus1 ();

   hazard_forward_unit #(.REG_AW(5), .RF_WRITE_FIRST(1'b1), .CNT_W(16)) u0 (
      .clk(clk), .reset(reset), .bus(bus0));
   hazard_forward_unit #(.REG_AW(5), .RF_WRITE_FIRST(1'b0), .CNT_W(2)) u1 (
      .clk(clk), .reset(reset), .bus(bus1));

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;

   // reference model: per instance, slot 0 = E, 1 = M, 2 = W
   inst_t pipe [2][3];
   integer scnt [2];
   integer fcnt [2];
   int rfwf_m [2] = '{1, 0};
   int cmax_m [2] = '{65535, 3};
   out_t o0_last, o1_last;
   vec_t tab [24];

   function automatic stim_t mk_s(int rs1, int rs2, int rd, int v, int rw, int rsrc,
                                  int pc, int ext, int clr, int rst);
      stim_t s;
      s.rs1 = rs1[4:0]; s.rs2 = rs2[4:0]; s.rd = rd[4:0];
      s.v = v[0]; s.rw = rw[0]; s.rsrc = rsrc[1:0];
      s.pc = pc[0]; s.ext = ext[0]; s.clr = clr[0]; s.rst = rst[0];
      return s;
   endfunction

   function automatic out_t mk_o(int fa, int fb, int sf, int sd, int fd, int fe, int sc, int fc);
      out_t o;
      o.fa = fa; o.fb = fb; o.sf = sf; o.sd = sd; o.fd = fd; o.fe = fe; o.sc = sc; o.fc = fc;
      return o;
   endfunction

   function automatic void model_clear(int d);
      for (int k = 0; k < 3; k++) pipe[d][k] = '{rd: 0, rs1: 0, rs2: 0, wr: 1'b0, ld: 1'b0};
      scnt[d] = 0;
      fcnt[d] = 0;
   endfunction

   // 2 = from M, 1 = from W, 0 = regfile; the nearest older writer wins
   function automatic integer fwd_of(int d, int src);
      if (src == 0) return 0;
      for (int age = 1; age <= 2; age++)
         if (pipe[d][age].wr && pipe[d][age].rd == src) return (age == 1) ? 2 : 1;
      return 0;
   endfunction

   function automatic out_t predict(int d, stim_t s);
      out_t o;
      bit ld_hit, wd_hit, hz;
      inst_t e, w;
      e = pipe[d][0];
      w = pipe[d][2];
      o.fa = fwd_of(d, e.rs1);
      o.fb = fwd_of(d, e.rs2);
      ld_hit = e.ld && e.rd != 0 && (e.rd == int'(s.rs1) || e.rd == int'(s.rs2));
      wd_hit = rfwf_m[d] == 0 && w.wr && w.rd != 0 && (w.rd == int'(s.rs1) || w.rd == int'(s.rs2));
      hz = s.v && (ld_hit || wd_hit);
      o.sf = 0; o.sd = 0; o.fd = 0; o.fe = 0;
      if (s.ext) begin o.sf = 1; o.sd = 1; end
      else if (s.pc) begin o.fd = 1; o.fe = 1; end
      else if (hz) begin o.sf = 1; o.sd = 1; o.fe = 1; end
      o.sc = scnt[d];
      o.fc = fcnt[d];
      return o;
   endfunction

   function automatic void advance(int d, stim_t s);
      out_t p;
      inst_t n;
      if (s.rst) begin
         model_clear(d);
      end else if (!s.ext) begin
         p = predict(d, s);
         if (s.clr) begin
            scnt[d] = 0; fcnt[d] = 0;
         end else begin
            if (p.sf == 1 && scnt[d] < cmax_m[d]) scnt[d] = scnt[d] + 1;
            if (s.pc && fcnt[d] < cmax_m[d]) fcnt[d] = fcnt[d] + 1;
         end
         pipe[d][2] = pipe[d][1];
         pipe[d][1] = pipe[d][0];
         if (p.fe == 1) n = '{rd: 0, rs1: 0, rs2: 0, wr: 1'b0, ld: 1'b0};
         else n = '{rd: int'(s.rd), rs1: int'(s.rs1), rs2: int'(s.rs2),
                    wr: s.rw && s.v, ld: s.rsrc == 2'b01};
         pipe[d][0] = n;
      end
   endfunction

   task automatic check(input string nm, input integer act, input integer exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic cmp_out(input string tag, input out_t a, input out_t e);
      check({tag, ".fwd_a_e"}, a.fa, e.fa);
      check({tag, ".fwd_b_e"}, a.fb, e.fb);
      check({tag, ".stall_f"}, a.sf, e.sf);
      check({tag, ".stall_d"}, a.sd, e.sd);
      check({tag, ".flush_d"}, a.fd, e.fd);
      check({tag, ".flush_e"}, a.fe, e.fe);
      check({tag, ".stall_cnt"}, a.sc, e.sc);
      check({tag, ".flush_cnt"}, a.fc, e.fc);
   endtask

   function automatic out_t sample0();
      out_t o;
      o.fa = bus0.fwd_a_e; o.fb = bus0.fwd_b_e;
      o.sf = bus0.stall_f; o.sd = bus0.stall_d; o.fd = bus0.flush_d; o.fe = bus0.flush_e;
      o.sc = bus0.stall_cnt; o.fc = bus0.flush_cnt;
      return o;
   endfunction

   function automatic out_t sample1();
      out_t o;
      o.fa = bus1.fwd_a_e; o.fb = bus1.fwd_b_e;
      o.sf = bus1.stall_f; o.sd = bus1.stall_d; o.fd = bus1.flush_d; o.fe = bus1.flush_e;
      o.sc = bus1.stall_cnt; o.fc = bus1.flush_cnt;
      return o;
   endfunction

   task automatic drive(input stim_t s);
      reset = s.rst;
      bus0.rs1_d = s.rs1; bus0.rs2_d = s.rs2; bus0.rd_d = s.rd;
      bus0.valid_d = s.v; bus0.regwrite_d = s.rw; bus0.result_src_d = s.rsrc;
      bus0.pcsrc_e = s.pc; bus0.ext_stall = s.ext; bus0.clr_cnt = s.clr;
      bus1.rs1_d = s.rs1; bus1.rs2_d = s.rs2; bus1.rd_d = s.rd;
      bus1.valid_d = s.v; bus1.regwrite_d = s.rw; bus1.result_src_d = s.rsrc;
      bus1.pcsrc_e = s.pc; bus1.ext_stall = s.ext; bus1.clr_cnt = s.clr;
   endtask

   // one cycle: drive after posedge, compare at negedge, advance model, next posedge
   task automatic step(input stim_t s, input bit tab_en, input out_t tab_o, input string tag);
      drive(s);
      @(negedge clk);
      o0_last = sample0();
      o1_last = sample1();
      cmp_out($sformatf("mdl0@%0d", cyc), o0_last, predict(0, s));
      cmp_out($sformatf("mdl1@%0d", cyc), o1_last, predict(1, s));
      if (tab_en) cmp_out(tag, o0_last, tab_o);
      advance(0, s);
      advance(1, s);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] rreg();
      int t;
      t = $urandom_range(0, 7);
      return t[4:0];
   endfunction

   function automatic stim_t rnd_stim();
      stim_t s;
      int t;
      s.rs1 = rreg(); s.rs2 = rreg(); s.rd = rreg();
      s.v   = ($urandom_range(0, 9) != 0);
      s.rw  = ($urandom_range(0, 9) < 7);
      t = $urandom_range(0, 3);
      s.rsrc = t[1:0];
      s.pc  = ($urandom_range(0, 9) == 0);
      s.ext = ($urandom_range(0, 9) == 0);
      s.clr = ($urandom_range(0, 49) == 0);
      s.rst = ($urandom_range(0, 99) == 0);
      return s;
   endfunction

   initial begin
      stim_t idle, s;
      out_t none;
      idle = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      none = mk_o(0, 0, 0, 0, 0, 0, 0, 0);

      // forwarding: M/W priority, W-only
      tab[0]  = '{mk_s(1, 2, 5, 1, 1, 0, 0, 0, 0, 0),  mk_o(0, 0, 0, 0, 0, 0, 0, 0)};
      tab[1]  = '{mk_s(1, 2, 5, 1, 1, 0, 0, 0, 0, 0),  mk_o(0, 0, 0, 0, 0, 0, 0, 0)};
      tab[2]  = '{mk_s(5, 9, 7, 1, 1, 0, 0, 0, 0, 0),  mk_o(0, 0, 0, 0, 0, 0, 0, 0)};
      tab[3]  = '{mk_s(3, 7, 10, 1, 1, 0, 0, 0, 0, 0), mk_o(2, 0, 0, 0, 0, 0, 0, 0)};
      tab[4]  = '{mk_s(7, 0, 11, 1, 1, 0, 0, 0, 0, 0), mk_o(0, 2, 0, 0, 0, 0, 0, 0)};
      tab[5]  = '{idle,                                mk_o(1, 0, 0, 0, 0, 0, 0, 0)};
      // load-use: one bubble then W forwarding
      tab[6]  = '{mk_s(1, 0, 6, 1, 1, 1, 0, 0, 0, 0),  mk_o(0, 0, 0, 0, 0, 0, 0, 0)};
      tab[7]  = '{mk_s(2, 6, 12, 1, 1, 0, 0, 0, 0, 0), mk_o(0, 0, 1, 1, 0, 1, 0, 0)};
      tab[8]  = '{mk_s(2, 6, 12, 1, 1, 0, 0, 0, 0, 0), mk_o(0, 0, 0, 0, 0, 0, 1, 0)};
      tab[9]  = '{idle,                                mk_o(0, 1, 0, 0, 0, 0, 1, 0)};
      // load to x0, x0 reads
      tab[10] = '{mk_s(1, 0, 0, 1, 1, 1, 0, 0, 0, 0),  mk_o(0, 0, 0, 0, 0, 0, 1, 0)};
      tab[11] = '{mk_s(0, 0, 13, 1, 1, 0, 0, 0, 0, 0), mk_o(0, 0, 0, 0, 0, 0, 1, 0)};
      tab[12] = '{idle,                                mk_o(0, 0, 0, 0, 0, 0, 1, 0)};
      // taken branch masks a load-use hazard
      tab[13] = '{mk_s(1, 0, 6, 1, 1, 1, 0, 0, 0, 0),  mk_o(0, 0, 0, 0, 0, 0, 1, 0)};
      tab[14] = '{mk_s(6, 2, 14, 1, 1, 0, 1, 0, 0, 0), mk_o(0, 0, 0, 0, 1, 1, 1, 0)};
      tab[15] = '{idle,                                mk_o(0, 0, 0, 0, 0, 0, 1, 1)};
      // freeze over a pending branch, flush after release
      tab[16] = '{mk_s(6, 0, 15, 1, 1, 0, 1, 1, 0, 0), mk_o(0, 0, 1, 1, 0, 0, 1, 1)};
      tab[17] = '{mk_s(6, 0, 15, 1, 1, 0, 1, 1, 0, 0), mk_o(0, 0, 1, 1, 0, 0, 1, 1)};
      tab[18] = '{mk_s(6, 0, 15, 1, 1, 0, 1, 1, 0, 0), mk_o(0, 0, 1, 1, 0, 0, 1, 1)};
      tab[19] = '{mk_s(6, 0, 15, 1, 1, 0, 1, 0, 0, 0), mk_o(0, 0, 0, 0, 1, 1, 1, 1)};
      tab[20] = '{idle,                                mk_o(0, 0, 0, 0, 0, 0, 1, 2)};
      // reset during a stall
      tab[21] = '{mk_s(1, 0, 6, 1, 1, 1, 0, 0, 0, 0),  mk_o(0, 0, 0, 0, 0, 0, 1, 2)};
      tab[22] = '{mk_s(6, 0, 16, 1, 1, 0, 0, 0, 0, 1), mk_o(0, 0, 1, 1, 0, 1, 1, 2)};
      tab[23] = '{idle,                                mk_o(0, 0, 0, 0, 0, 0, 0, 0)};

      s = idle;
      s.rst = 1'b1;
      drive(s);
      model_clear(0);
      model_clear(1);
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 24; i++) step(tab[i].s, 1'b1, tab[i].o, $sformatf("tab[%0d]", i));

      // five load-use stalls: 16-bit counter reaches 5, 2-bit counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         step(mk_s(1, 0, 6, 1, 1, 1, 0, 0, 0, 0), 1'b0, none, "");
         step(mk_s(6, 0, 20, 1, 1, 0, 0, 0, 0, 0), 1'b0, none, "");
         step(mk_s(6, 0, 20, 1, 1, 0, 0, 0, 0, 0), 1'b0, none, "");
      end
      step(idle, 1'b0, none, "");
      check("sat.u0_stall_cnt", o0_last.sc, 5);
      check("sat.u1_stall_cnt", o1_last.sc, 3);
      s = idle;
      s.clr = 1'b1;
      step(s, 1'b0, none, "");
      step(idle, 1'b0, none, "");
      check("clr.u0_stall_cnt", o0_last.sc, 0);
      check("clr.u1_stall_cnt", o1_last.sc, 0);

      // W-vs-D match stalls only the write-late instance
      step(mk_s(1, 2, 9, 1, 1, 0, 0, 0, 0, 0), 1'b0, none, "");
      step(idle, 1'b0, none, "");
      step(idle, 1'b0, none, "");
      step(mk_s(9, 0, 21, 1, 1, 0, 0, 0, 0, 0), 1'b0, none, "");
      check("wd.u1_stall_d", o1_last.sd, 1);
      check("wd.u1_flush_e", o1_last.fe, 1);
      check("wd.u0_stall_d", o0_last.sd, 0);
      step(mk_s(9, 0, 21, 1, 1, 0, 0, 0, 0, 0), 1'b0, none, "");
      check("wd.u1_stall_cnt", o1_last.sc, 1);
      check("wd.u0_stall_cnt", o0_last.sc, 0);

      for (int i = 0; i < 3000; i++) step(rnd_stim(), 1'b0, none, "");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
